// File: rtl/sseg_scan_mux.sv
// Time-multiplexed seven-segment scanner with dp, blank, blink, PWM dimming and per-slot dead time.
// Outputs are registered one clk after counter state; no backpressure, en=0 freezes counters and blanks.
module sseg_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 50000,
  parameter int BLINK_W        = 24,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic AN_OFF  = (AN_ACTIVE_LOW != 0);
  localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0]      presc;
  logic [IW-1:0]      idx;
  logic [3:0]         pwm_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               presc_wrap;
  logic               idx_wrap;

  assign presc_wrap = (presc == PW'(TICK_DIV - 1));
  assign idx_wrap   = (idx == IW'(NUM_DIGITS - 1));
  assign digit_idx  = idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc      <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      blink_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= en & presc_wrap & idx_wrap;
      if (en) begin
        pwm_cnt   <= pwm_cnt + 4'd1;
        blink_cnt <= blink_cnt + 1'b1;
        if (presc_wrap) begin
          presc <= '0;
          idx   <= idx_wrap ? '0 : idx + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  logic [6:0]            seg_sel;
  logic                  dp_sel;
  logic                  blank_sel;
  logic                  blink_sel;
  logic                  pwm_on;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            sseg_nxt;
  logic                  dp_nxt;

  // Explicit mux keeps non-power-of-2 digit counts from indexing past the bus.
  always_comb begin
    seg_sel   = 7'h00;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    blink_sel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        seg_sel   = seg_in[7*k +: 7];
        dp_sel    = dp_in[k];
        blank_sel = blank_in[k];
        blink_sel = blink_in[k];
      end
    end
  end

  always_comb begin
    pwm_on = (brightness == 4'hF) || (pwm_cnt < brightness);
    lit    = en && (presc != '0) && pwm_on && !blank_sel &&
             !(blink_sel && blink_cnt[BLINK_W-1]);
    an_nxt   = {NUM_DIGITS{AN_OFF}};
    sseg_nxt = {7{SEG_OFF}};
    dp_nxt   = SEG_OFF;
    if (lit) begin
      an_nxt   = (NUM_DIGITS'(1) << idx) ^ {NUM_DIGITS{AN_OFF}};
      sseg_nxt = seg_sel ^ {7{SEG_OFF}};
      dp_nxt   = dp_sel ^ SEG_OFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= {NUM_DIGITS{AN_OFF}};
      sseg <= {7{SEG_OFF}};
      dp   <= SEG_OFF;
    end else begin
      an   <= an_nxt;
      sseg <= sseg_nxt;
      dp   <= dp_nxt;
    end
  end

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
Parametrised time-multiplexed driver for a common-anode/cathode multi-digit seven-segment display. It scans NUM_DIGITS digit codes onto a shared segment bus and adds the following per digit:
- decimal point
- blanking
- blinking
- global PWM brightness
- one-cycle anti-ghosting dead time on each digit change

It sits between the seven-segment decoders and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8).
TICK_DIV, 50000, clocks per digit slot (>=4); prescaler terminal count is TICK_DIV-1.
BLINK_W, 24, width of free-running blink counter; blink phase = counter MSB.
AN_ACTIVE_LOW, 1, 1 = anodes active low, 0 = active high.
SEG_ACTIVE_LOW, 1, 1 = segments/dp active low, 0 = active high.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  scan enable; 0 freezes counters and blanks display
seg_in  in  7*NUM_DIGITS  segment codes, digit k at [7k+6:7k], active-high logical (bit0=a..bit6=g)
dp_in  in  NUM_DIGITS  decimal point request per digit, active-high logical
blank_in  in  NUM_DIGITS  1 = digit k never lit
blink_in  in  NUM_DIGITS  1 = digit k dark while blink phase=1
brightness  in  4  global duty: 0=off, 15=full on
an  out  NUM_DIGITS  digit enables, physical polarity per AN_ACTIVE_LOW
sseg  out  7  segment lines, physical polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point line, physical polarity per SEG_ACTIVE_LOW
digit_idx  out  max(1,$clog2(NUM_DIGITS))  index of digit currently in slot
frame_tick  out  1  one-cycle pulse when digit_idx wraps NUM_DIGITS-1 -> 0

Behaviour:
- Reset: applies asynchronously; all internal counters are 0. Output values while reset is asserted:
  - an: all inactive
  - sseg: all segments off (physical)
  - dp: off
  - digit_idx: 0
  - frame_tick: 0
- Reset mid-scan: returns to these values immediately. First slot after release is digit 0.
- Prescaler: increments each clk while en=1. At TICK_DIV-1 it wraps to 0 and digit_idx advances by 1 modulo NUM_DIGITS (non-power-of-2 counts wrap correctly).
- frame_tick: asserts in the same cycle that digit_idx updates from NUM_DIGITS-1 to 0.
- Dead time: while prescaler==0 (first clock of every slot, including after reset), all anodes are inactive.
- PWM: 4-bit pwm counter increments every clk while en=1, wrapping 15->0. Digit is lit when brightness==15 OR pwm_cnt < brightness. brightness=0 means never lit.
- Blink: BLINK_W-bit counter free-runs while en=1. Digit k is dark when blink_in[k]=1 and the counter MSB is 1.
- Lit condition for digit d=digit_idx: en & ~dead & pwm_on & ~blank_in[d] & ~(blink_in[d] & blink_msb).
- Lit output:
  - exactly one anode active (bit d)
  - sseg = seg_in[d] mapped to physical polarity
  - dp = dp_in[d] mapped
- Unlit output: all anodes inactive; sseg and dp at physical off level.
- Latency: an/sseg/dp are registered, one clk after the counter state and sampled inputs. Input changes appear on the next clk regardless of slot position.
- en=0: all counters hold, outputs go to unlit within 1 clk. Resuming continues from the held state.
- One-hot guarantee: an never has more than one active bit.

Test Plan:
- Params NUM_DIGITS=4, TICK_DIV=4, polarities 1; reset held 3 clk -> an=4'b1111, sseg=7'h7F, dp=1. After release, digit_idx steps 0,1,2,3,0 every 4 clk; frame_tick pulses once per 16 clk.
- seg_in={7'h06,7'h5B,7'h4F,7'h66}, brightness=15 -> in slot 0 after dead clk: an=4'b1110, sseg=~7'h66. Slot 2: an=4'b1011, sseg=~7'h5B. Dead clk shows an=4'b1111.
- blank_in=4'b0010 -> slot 1 always an=4'b1111. blink_in=4'b0001 with BLINK_W=4 -> digit 0 lit only while blink MSB=0 (8 of 16 clk windows).
- brightness=4 with TICK_DIV=32 -> in a steady slot, the digit is active 4 of every 16 clk. brightness=0 -> an stays 4'b1111.
- en dropped mid-slot at prescaler=2 -> next clk an=4'b1111 and counters frozen. en restored -> digit_idx unchanged, slot completes 2 clk later.
- NUM_DIGITS=3, AN_ACTIVE_LOW=0 -> an sequences 3'b001,3'b010,3'b100 and idx wraps 2->0 with frame_tick. Async reset asserted mid-cycle clears an to 3'b000 before the next edge.
